// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit. The E-stage controller
// and the hazard unit decode the same encodings.
//   - md_op_e    : 3-bit op codes driven on md_unit.op
//   - md_state_e : FSM state encoding of md_unit
//   - md_is_mul / md_is_div / md_is_signed : op classification helpers
// ---------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // True for ops that run the multiplier.
    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for ops that run the divider.
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for ops that treat their operands as two's complement.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit with HI/LO registers, placed in E stage.
// mult/multu/div/divu latch their operands and hold busy for a fixed number
// of cycles, then commit {hi,lo}. mthi/mtlo write HI/LO on the next edge
// without going busy.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset
//   start  in   1      E-stage instruction is an md op (sampled when idle)
//   op     in   3      md_pkg::md_op_e code
//   a      in   WIDTH  rs operand
//   b      in   WIDTH  rt operand
//   busy   out  1      operation in flight (registered)
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// ---------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0]    CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_MUL_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] W_ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_latch;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;

    // Arithmetic datapath, fed only from the operand latches.
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_div_den;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Sign/zero extension to 2*WIDTH makes one truncated product serve both
    // signed and unsigned multiplies.
    assign w_ext_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division is done on magnitudes and the signs restored after.
    // For -2^(WIDTH-1) / -1 the magnitude quotient is 2^(WIDTH-1) with no
    // negation, which is exactly the required wrapped result.
    assign w_a_neg    = r_signed & r_a[WIDTH-1];
    assign w_b_neg    = r_signed & r_b[WIDTH-1];
    assign w_mag_a    = w_a_neg ? (~r_a + W_ONE) : r_a;
    assign w_mag_b    = w_b_neg ? (~r_b + W_ONE) : r_b;
    assign w_div_zero = (r_b == W_ZERO);
    // Keep the divider away from a zero denominator; the result is discarded.
    assign w_div_den  = w_div_zero ? W_ONE : w_mag_b;
    assign w_q_mag    = w_mag_a / w_div_den;
    assign w_r_mag    = w_mag_a % w_div_den;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + W_ONE) : w_q_mag;
    assign w_rem      = w_a_neg ? (~w_r_mag + W_ONE) : w_r_mag;

    // FSM state, cycle counter and busy flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and counter logic; start is only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && md_is_mul(op)) begin
                    w_state_nxt = ST_MUL;
                    w_cnt_nxt   = CNT_MUL_LOAD;
                    w_latch     = 1'b1;
                end else if (start && md_is_div(op)) begin
                    w_state_nxt = ST_DIV;
                    w_cnt_nxt   = CNT_DIV_LOAD;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Output logic: next busy and the HI/LO write values.
    always_comb begin
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (start && (op == MD_MTHI)) begin
                    w_hi_nxt = a;
                end else if (start && (op == MD_MTLO)) begin
                    w_lo_nxt = a;
                end else begin
                    w_hi_nxt = r_hi;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_ZERO) begin
                    w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_nxt = w_prod[WIDTH-1:0];
                end else begin
                    w_hi_nxt = r_hi;
                end
            end
            ST_DIV: begin
                // Divide by zero runs the full time but leaves HI/LO alone.
                if ((r_cnt == CNT_ZERO) && !w_div_zero) begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quot;
                end else begin
                    w_hi_nxt = r_hi;
                end
            end
            default: begin
                w_hi_nxt = r_hi;
                w_lo_nxt = r_lo;
            end
        endcase
    end

    // Operand and signedness latches, loaded when an operation is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= W_ZERO;
            r_b      <= W_ZERO;
            r_signed <= 1'b0;
        end else if (w_latch) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= md_is_signed(op);
        end else begin
            r_a      <= r_a;
            r_b      <= r_b;
            r_signed <= r_signed;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= W_ZERO;
            r_lo <= W_ZERO;
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Directed self-checking bench for md_unit (WIDTH=32, 5-cycle multiply,
// 10-cycle divide). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    md_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue a busy-type op, scramble the operand inputs while it runs, count
    // busy cycles (bounded) and check the committed HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] xa, input logic [31:0] xb,
                          input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        start = 1'b1; op = o; a = xa; b = xb;
        tick();
        start = 1'b0; op = MD_NOP; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A;
        n = 0;
        while ((busy === 1'b1) && (n < 64)) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0; start = 1'b0; op = MD_NOP; a = 32'h0; b = 32'h0;

        // Reset state
        #12;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        reset = 1'b1;
        tick();

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = MD_MTHI; a = 32'h0000_1234;
        tick();
        chk("mthi_busy", {63'h0, busy}, 64'h0);
        chk("mthi_hi", {32'h0, hi}, 64'h1234);
        chk("mthi_lo", {32'h0, lo}, 64'h0);
        op = MD_MTLO; a = 32'h0000_5678;
        tick();
        start = 1'b0; op = MD_NOP;
        chk("mtlo_busy", {63'h0, busy}, 64'h0);
        chk("mtlo_hi", {32'h0, hi}, 64'h1234);
        chk("mtlo_lo", {32'h0, lo}, 64'h5678);

        // Arithmetic
        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'h0000_0001, 32'h0000_0003);
        run_op("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        // Divide by zero leaves HI/LO alone
        start = 1'b1; op = MD_MTHI; a = 32'd9;
        tick();
        op = MD_MTLO; a = 32'd9;
        tick();
        start = 1'b0; op = MD_NOP;
        run_op("div_zero", MD_DIV, 32'd5, 32'd0, 10, 32'd9, 32'd9);

        // Invalid op codes are no-ops
        start = 1'b1; op = MD_RSVD; a = 32'hDEAD_BEEF; b = 32'h1;
        tick();
        chk("inv7_busy", {63'h0, busy}, 64'h0);
        op = MD_NOP;
        tick();
        start = 1'b0;
        chk("inv0_busy", {63'h0, busy}, 64'h0);
        chk("inv_hi", {32'h0, hi}, 64'd9);
        chk("inv_lo", {32'h0, lo}, 64'd9);

        // start during busy: MTLO and MULT ignored until the MULT 3*4 finishes
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        tick();
        op = MD_MTLO; a = 32'hDEAD_0001;
        tick();
        chk("busy_mtlo_lo", {32'h0, lo}, 64'd9);
        op = MD_MULT; a = 32'd100; b = 32'd100;
        tick();
        chk("busy_mult_lo", {32'h0, lo}, 64'd9);
        chk("busy_still", {63'h0, busy}, 64'h1);
        start = 1'b0; op = MD_NOP;
        tick();
        tick();
        chk("busy_last", {63'h0, busy}, 64'h1);
        tick();
        chk("busy_done", {63'h0, busy}, 64'h0);
        chk("busy_hi", {32'h0, hi}, 64'd0);
        chk("busy_lo", {32'h0, lo}, 64'd12);

        // Reset during the 4th busy cycle of a DIV aborts it
        start = 1'b1; op = MD_MTHI; a = 32'd21;
        tick();
        op = MD_DIV; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; op = MD_NOP;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {63'h0, busy}, 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_hi", {32'h0, hi}, 64'h0);
        chk("midrst_lo", {32'h0, lo}, 64'h0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("postrst_busy", {63'h0, busy}, 64'h0);
        chk("postrst_hi", {32'h0, hi}, 64'h0);
        chk("postrst_lo", {32'h0, lo}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
